// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the data-memory arbiter and the data memory.
//   - Memory op codes (2-bit WrRd): OP_IDLE, OP_READ, OP_WRITE.
//   - Arbiter FSM state codes: ST_IDLE, ST_ISSUE, ST_RESP.
//   - Source ids, which are also the bit positions in the one-hot grant:
//     SRC_BIP (bit 0), SRC_IF (bit 1).
package dmem_pkg;

    localparam logic [1:0] OP_IDLE  = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_WRITE = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    localparam logic SRC_BIP = 1'b0;
    localparam logic SRC_IF  = 1'b1;

    // Only read and write ever reach the memory. Codes 00 and 11 become an
    // idle cycle, so an illegal op can never reach the memory's case statement.
    function automatic logic [1:0] issue_op(input logic [1:0] op);
        return ((op == OP_READ) || (op == OP_WRITE)) ? op : OP_IDLE;
    endfunction

endpackage

// File: rtl/dmem_arbiter_arb2_pick.sv
// arb2_pick: combinational 2-way picker producing a one-hot grant.
//   req[1:0]   in   eligible requests, indexed by source id (bit 0 BIP, bit 1 IF)
//   last       in   source id of the previous grant
//   grant[1:0] out  one-hot grant, or 2'b00 when nothing is requested
// Build option: with DMEM_ARB_RR_EN defined, contention goes to the source that
// was not granted last (round-robin). Otherwise the interface always wins.
module arb2_pick
    import dmem_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant
);

`ifdef DMEM_ARB_RR_EN
    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = (last == SRC_IF) ? 2'b01 : 2'b10;
        end
    end
`else
    // last_grant is tracked by the top in both builds but has no effect here.
    logic unused_last;
    assign unused_last = last;

    always_comb begin
        grant = req;
        if (req[SRC_IF]) begin
            grant = 2'b10;
        end
    end
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port, negedge-clocked data memory between the
// BIP core and the debug/UART interface, one access per two cycles.
//   clk, rst_n                 clock; synchronous active-low reset
//   bip_req/op/addr/wdata      BIP request (op 10 = write, 01 = read)
//   bip_ack, bip_rvalid        one-cycle pulses: accepted / bip_rdata valid
//   bip_rdata                  BIP read data, held until the next BIP read
//   if_*                       same set for the interface side
//   if_lock                    while high, BIP requests are never granted
//   mem_wrrd/addr/wdata        drive the memory's BIP-side port
//   mem_rdata                  memory output data
//   busy                       high while the FSM is in ISSUE
// Build option: DMEM_ARB_RR_EN selects round-robin instead of interface-first
// priority on contention (see arb2_pick).
// Timing: request sampled at edge k -> ack and memory op in cycle k+1 (memory
// executes at that cycle's negedge) -> mem_rdata latched at edge k+2.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_LENGTH = 11,
    parameter int DATA_LENGTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   bip_req,
    input  logic [1:0]             bip_op,
    input  logic [ADDR_LENGTH-1:0] bip_addr,
    input  logic [DATA_LENGTH-1:0] bip_wdata,
    output logic                   bip_ack,
    output logic                   bip_rvalid,
    output logic [DATA_LENGTH-1:0] bip_rdata,
    input  logic                   if_req,
    input  logic [1:0]             if_op,
    input  logic [ADDR_LENGTH-1:0] if_addr,
    input  logic [DATA_LENGTH-1:0] if_wdata,
    output logic                   if_ack,
    output logic                   if_rvalid,
    output logic [DATA_LENGTH-1:0] if_rdata,
    input  logic                   if_lock,
    output logic [1:0]             mem_wrrd,
    output logic [ADDR_LENGTH-1:0] mem_addr,
    output logic [DATA_LENGTH-1:0] mem_wdata,
    input  logic [DATA_LENGTH-1:0] mem_rdata,
    output logic                   busy
);

    state_t                 state_reg, state_next;
    logic [1:0]             op_reg;
    logic [ADDR_LENGTH-1:0] addr_reg;
    logic [DATA_LENGTH-1:0] wdata_reg;
    logic                   src_reg;
    logic                   last_grant_reg;
    logic                   bip_ack_reg, if_ack_reg;
    logic                   bip_rvalid_reg, if_rvalid_reg;
    logic [DATA_LENGTH-1:0] bip_rdata_reg, if_rdata_reg;

    logic [1:0] eligible;
    logic [1:0] grant;
    logic       take;
    logic       rd_done;
    logic       win_src;

    assign eligible = {if_req, bip_req & ~if_lock};

    arb2_pick u_pick (
        .req   (eligible),
        .last  (last_grant_reg),
        .grant (grant)
    );

    assign win_src = grant[SRC_IF] ? SRC_IF : SRC_BIP;

    // Read data comes back at the edge that ends ISSUE. Reset at that same edge
    // takes priority in the sequential block, which suppresses the rvalid.
    assign rd_done = (state_reg == ST_ISSUE) && (op_reg == OP_READ);

    always_comb begin
        state_next = state_reg;
        take       = 1'b0;
        busy       = 1'b0;
        mem_wrrd   = OP_IDLE;
        case (state_reg)
            ST_IDLE: begin
                if (|grant) begin
                    take       = 1'b1;
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                busy       = 1'b1;
                mem_wrrd   = issue_op(op_reg);
                state_next = ST_RESP;
            end
            ST_RESP: begin
                take       = |grant;
                state_next = (|grant) ? ST_ISSUE : ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            op_reg         <= OP_IDLE;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            src_reg        <= SRC_BIP;
            last_grant_reg <= SRC_BIP;
            bip_ack_reg    <= 1'b0;
            if_ack_reg     <= 1'b0;
            bip_rvalid_reg <= 1'b0;
            if_rvalid_reg  <= 1'b0;
            bip_rdata_reg  <= '0;
            if_rdata_reg   <= '0;
        end else begin
            state_reg   <= state_next;
            bip_ack_reg <= take & grant[SRC_BIP];
            if_ack_reg  <= take & grant[SRC_IF];
            if (take) begin
                src_reg        <= win_src;
                last_grant_reg <= win_src;
                op_reg         <= (win_src == SRC_IF) ? if_op    : bip_op;
                addr_reg       <= (win_src == SRC_IF) ? if_addr  : bip_addr;
                wdata_reg      <= (win_src == SRC_IF) ? if_wdata : bip_wdata;
            end
            bip_rvalid_reg <= rd_done && (src_reg == SRC_BIP);
            if_rvalid_reg  <= rd_done && (src_reg == SRC_IF);
            if (rd_done && (src_reg == SRC_BIP)) begin
                bip_rdata_reg <= mem_rdata;
            end
            if (rd_done && (src_reg == SRC_IF)) begin
                if_rdata_reg <= mem_rdata;
            end
        end
    end

    assign bip_ack    = bip_ack_reg;
    assign if_ack     = if_ack_reg;
    assign bip_rvalid = bip_rvalid_reg;
    assign if_rvalid  = if_rvalid_reg;
    assign bip_rdata  = bip_rdata_reg;
    assign if_rdata   = if_rdata_reg;
    assign mem_addr   = addr_reg;
    assign mem_wdata  = wdata_reg;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: self-checking bench for dmem_arbiter with a negedge-clocked
// data memory model preloaded with [1,2,3,4,0,0]. Each table row is one cycle:
// inputs are applied just after a posedge and the row's expected outputs are
// those seen just after the next posedge. Multi-cycle reset corner is hand-coded.
module tb_dmem_arbiter;
    import dmem_pkg::*;

    localparam int AW = 11;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          bip_req, if_req, if_lock;
    logic [1:0]    bip_op, if_op;
    logic [AW-1:0] bip_addr, if_addr;
    logic [DW-1:0] bip_wdata, if_wdata;
    logic          bip_ack, bip_rvalid, if_ack, if_rvalid, busy;
    logic [DW-1:0] bip_rdata, if_rdata;
    logic [1:0]    mem_wrrd;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    logic [DW-1:0] tb_mem [0:(1<<AW)-1];

    int checks = 0;
    int errors = 0;
    int bad_op_cycles = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_LENGTH(AW), .DATA_LENGTH(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .bip_req(bip_req), .bip_op(bip_op), .bip_addr(bip_addr), .bip_wdata(bip_wdata),
        .bip_ack(bip_ack), .bip_rvalid(bip_rvalid), .bip_rdata(bip_rdata),
        .if_req(if_req), .if_op(if_op), .if_addr(if_addr), .if_wdata(if_wdata),
        .if_ack(if_ack), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .if_lock(if_lock),
        .mem_wrrd(mem_wrrd), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    // Data memory model: single port, executes at negedge.
    always @(negedge clk) begin
        if (mem_wrrd == 2'b11) bad_op_cycles++;
        case (mem_wrrd)
            OP_WRITE: tb_mem[mem_addr] <= mem_wdata;
            OP_READ:  mem_rdata <= tb_mem[mem_addr];
            default:  ;
        endcase
    end

    typedef struct {
        logic          br;  logic [1:0] bop; logic [AW-1:0] ba;
        logic          ir;  logic [1:0] iop; logic [AW-1:0] ia;
        logic [DW-1:0] wd;  logic lk;
        logic          e_back; logic e_bval; logic [DW-1:0] e_bdat;
        logic          e_iack; logic e_ival; logic [DW-1:0] e_idat;
        logic [1:0]    e_wrrd; logic [AW-1:0] e_addr; logic e_busy;
    } vec_t;

    vec_t vecs[$];

    task automatic v(input logic br, input logic [1:0] bop, input int ba,
                     input logic ir, input logic [1:0] iop, input int ia,
                     input int wd, input logic lk,
                     input logic eb, input logic ebv, input int ebd,
                     input logic ei, input logic eiv, input int eid,
                     input logic [1:0] ew, input int ea, input logic ebz);
        vec_t r;
        r.br = br; r.bop = bop; r.ba = AW'(ba);
        r.ir = ir; r.iop = iop; r.ia = AW'(ia);
        r.wd = DW'(wd); r.lk = lk;
        r.e_back = eb; r.e_bval = ebv; r.e_bdat = DW'(ebd);
        r.e_iack = ei; r.e_ival = eiv; r.e_idat = DW'(eid);
        r.e_wrrd = ew; r.e_addr = AW'(ea); r.e_busy = ebz;
        vecs.push_back(r);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, " bip_ack"},    32'(bip_ack),    0);
        chk({tag, " if_ack"},     32'(if_ack),     0);
        chk({tag, " bip_rvalid"}, 32'(bip_rvalid), 0);
        chk({tag, " if_rvalid"},  32'(if_rvalid),  0);
        chk({tag, " bip_rdata"},  32'(bip_rdata),  0);
        chk({tag, " if_rdata"},   32'(if_rdata),   0);
        chk({tag, " mem_wrrd"},   32'(mem_wrrd),   0);
        chk({tag, " mem_addr"},   32'(mem_addr),   0);
        chk({tag, " mem_wdata"},  32'(mem_wdata),  0);
        chk({tag, " busy"},       32'(busy),       0);
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) tb_mem[i] = '0;
        for (int i = 0; i < 4; i++) tb_mem[i] = DW'(i + 1);
        mem_rdata = '0;

        // ---- vector table ----
        // Single BIP read of addr 2 -> 3.
        v(1,1,2, 0,0,0, 0,0,  1,0,0, 0,0,0, 2'b01,2,1);
        v(0,0,0, 0,0,0, 0,0,  0,1,3, 0,0,0, 2'b00,2,0);
        v(0,0,0, 0,0,0, 0,0,  0,0,3, 0,0,0, 2'b00,2,0);
        // Contention: IF reads addr 0, BIP reads addr 1, both held.
`ifdef DMEM_ARB_RR_EN
        v(1,1,1, 1,1,0, 0,0,  0,0,3, 1,0,0, 2'b01,0,1);
        v(1,1,1, 1,1,0, 0,0,  0,0,3, 0,1,1, 2'b00,0,0);
        v(1,1,1, 1,1,0, 0,0,  1,0,3, 0,0,1, 2'b01,1,1);
        v(1,1,1, 1,1,0, 0,0,  0,1,2, 0,0,1, 2'b00,1,0);
        v(1,1,1, 1,1,0, 0,0,  0,0,2, 1,0,1, 2'b01,0,1);
        v(1,1,1, 0,0,0, 0,0,  0,0,2, 0,1,1, 2'b00,0,0);
        v(1,1,1, 0,0,0, 0,0,  1,0,2, 0,0,1, 2'b01,1,1);
        v(0,0,0, 0,0,0, 0,0,  0,1,2, 0,0,1, 2'b00,1,0);
`else
        v(1,1,1, 1,1,0, 0,0,  0,0,3, 1,0,0, 2'b01,0,1);
        v(1,1,1, 1,1,0, 0,0,  0,0,3, 0,1,1, 2'b00,0,0);
        v(1,1,1, 1,1,0, 0,0,  0,0,3, 1,0,1, 2'b01,0,1);
        v(1,1,1, 1,1,0, 0,0,  0,0,3, 0,1,1, 2'b00,0,0);
        v(1,1,1, 1,1,0, 0,0,  0,0,3, 1,0,1, 2'b01,0,1);
        v(1,1,1, 0,0,0, 0,0,  0,0,3, 0,1,1, 2'b00,0,0);
        v(1,1,1, 0,0,0, 0,0,  1,0,3, 0,0,1, 2'b01,1,1);
        v(0,0,0, 0,0,0, 0,0,  0,1,2, 0,0,1, 2'b00,1,0);
`endif
        v(0,0,0, 0,0,0, 0,0,  0,0,2, 0,0,1, 2'b00,1,0);
        // IF write addr 4 = 0x00AA, next request presented in the ack cycle, then read back.
        v(0,0,0, 1,2,4, 'hAA,0, 0,0,2, 1,0,1, 2'b10,4,1);
        v(0,0,0, 1,1,4, 0,0,  0,0,2, 0,0,1, 2'b00,4,0);
        v(0,0,0, 1,1,4, 0,0,  0,0,2, 1,0,1, 2'b01,4,1);
        v(0,0,0, 0,0,0, 0,0,  0,0,2, 0,1,'hAA, 2'b00,4,0);
        v(0,0,0, 0,0,0, 0,0,  0,0,2, 0,0,'hAA, 2'b00,4,0);
        // if_lock holds off a BIP read of addr 3 for 10 cycles, then releases it.
        for (int i = 0; i < 10; i++)
            v(1,1,3, 0,0,0, 0,1, 0,0,2, 0,0,'hAA, 2'b00,4,0);
        v(1,1,3, 0,0,0, 0,0,  1,0,2, 0,0,'hAA, 2'b01,3,1);
        v(0,0,0, 0,0,0, 0,0,  0,1,4, 0,0,'hAA, 2'b00,3,0);
        v(0,0,0, 0,0,0, 0,0,  0,0,4, 0,0,'hAA, 2'b00,3,0);
        // Lock rises during a granted BIP read: the access still completes.
        v(1,1,0, 0,0,0, 0,0,  1,0,4, 0,0,'hAA, 2'b01,0,1);
        v(0,0,0, 0,0,0, 0,1,  0,1,1, 0,0,'hAA, 2'b00,0,0);
        v(0,0,0, 0,0,0, 0,1,  0,0,1, 0,0,'hAA, 2'b00,0,0);
        // Illegal op 11: acked, no memory op, no rvalid; next read served normally.
        v(1,3,0, 0,0,0, 0,0,  1,0,1, 0,0,'hAA, 2'b00,0,1);
        v(0,0,0, 0,0,0, 0,0,  0,0,1, 0,0,'hAA, 2'b00,0,0);
        v(1,1,1, 0,0,0, 0,0,  1,0,1, 0,0,'hAA, 2'b01,1,1);
        v(0,0,0, 0,0,0, 0,0,  0,1,2, 0,0,'hAA, 2'b00,1,0);
        v(0,0,0, 0,0,0, 0,0,  0,0,2, 0,0,'hAA, 2'b00,1,0);

        // ---- reset ----
        rst_n = 1'b0;
        bip_req = 0; bip_op = 0; bip_addr = 0; bip_wdata = 0;
        if_req = 0; if_op = 0; if_addr = 0; if_wdata = 0; if_lock = 0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_state("reset");
        $display("txn reset: outputs at reset values, errors=%0d", errors);
        rst_n = 1'b1;

        // ---- table ----
        foreach (vecs[i]) begin
            bip_req = vecs[i].br; bip_op = vecs[i].bop; bip_addr = vecs[i].ba; bip_wdata = vecs[i].wd;
            if_req = vecs[i].ir; if_op = vecs[i].iop; if_addr = vecs[i].ia; if_wdata = vecs[i].wd;
            if_lock = vecs[i].lk;
            @(posedge clk);
            #1;
            chk($sformatf("row%0d bip_ack", i),    32'(bip_ack),    32'(vecs[i].e_back));
            chk($sformatf("row%0d bip_rvalid", i), 32'(bip_rvalid), 32'(vecs[i].e_bval));
            chk($sformatf("row%0d bip_rdata", i),  32'(bip_rdata),  32'(vecs[i].e_bdat));
            chk($sformatf("row%0d if_ack", i),     32'(if_ack),     32'(vecs[i].e_iack));
            chk($sformatf("row%0d if_rvalid", i),  32'(if_rvalid),  32'(vecs[i].e_ival));
            chk($sformatf("row%0d if_rdata", i),   32'(if_rdata),   32'(vecs[i].e_idat));
            chk($sformatf("row%0d mem_wrrd", i),   32'(mem_wrrd),   32'(vecs[i].e_wrrd));
            chk($sformatf("row%0d mem_addr", i),   32'(mem_addr),   32'(vecs[i].e_addr));
            chk($sformatf("row%0d busy", i),       32'(busy),       32'(vecs[i].e_busy));
            $display("txn row%0d: bip_ack=%0d bip_rv=%0d bip_rd=%0h if_ack=%0d if_rv=%0d if_rd=%0h wrrd=%0b addr=%0d busy=%0d",
                     i, bip_ack, bip_rvalid, bip_rdata, if_ack, if_rvalid, if_rdata, mem_wrrd, mem_addr, busy);
        end

        // ---- reset at the edge ending ISSUE of a BIP write (addr 5 = 7) ----
        bip_req = 1; bip_op = OP_WRITE; bip_addr = 5; bip_wdata = 7;
        @(posedge clk);
        #1;
        chk("rstmid ack", 32'(bip_ack), 1);
        chk("rstmid wrrd", 32'(mem_wrrd), 32'(OP_WRITE));
        bip_req = 0; bip_op = 0; bip_addr = 0; bip_wdata = 0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk_reset_state("rstmid");
        chk("rstmid mem[5]", 32'(tb_mem[5]), 7);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("post-reset%0d ack", i),    32'({bip_ack, if_ack}),       0);
            chk($sformatf("post-reset%0d rvalid", i), 32'({bip_rvalid, if_rvalid}), 0);
            chk($sformatf("post-reset%0d busy", i),   32'(busy),                    0);
        end
        $display("txn reset-mid-issue: mem[5]=%0h, errors=%0d", tb_mem[5], errors);

        chk("mem_wrrd 11 cycles", 32'(bad_op_cycles), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory (negedge-clocked, 2-bit WrRd op code: 10 = write, 01 = read) between the BIP core and the debug/UART interface.
- Serialises requests through a request/ack handshake and issues exactly one memory op per access.
- Returns read data to the winning requester with a registered valid pulse.
- Drives the memory's BIP-side port; the memory's interface-side op is tied to 2'b00, so the two case statements can never collide.

Parameters:
- ADDR_LENGTH, 11, address width of both requesters and the memory.
- DATA_LENGTH, 16, data word width.

Ports:
- clk  in  1  system clock; all arbiter state is updated on posedge.
- rst_n  in  1  reset, synchronous, active-low.
- bip_req  in  1  BIP access request.
- bip_op  in  2  10 = write, 01 = read.
- bip_addr  in  ADDR_LENGTH  BIP address.
- bip_wdata  in  DATA_LENGTH  BIP write data.
- bip_ack  out  1  one-cycle pulse: BIP request accepted.
- bip_rvalid  out  1  one-cycle pulse: bip_rdata valid.
- bip_rdata  out  DATA_LENGTH  BIP read data.
- if_req, if_op, if_addr, if_wdata, if_ack, if_rvalid, if_rdata  same shapes and meanings, interface side.
- if_lock  in  1  while high, BIP requests are never granted.
- mem_wrrd  out  2  to memory WrRdBip.
- mem_addr  out  ADDR_LENGTH  to memory addr_from_bip.
- mem_wdata  out  DATA_LENGTH  to memory data_from_bip.
- mem_rdata  in  DATA_LENGTH  from memory outData.
- busy  out  1  high while the FSM is in ISSUE.

Behaviour:
- Reset values (rst_n low at posedge): state IDLE; mem_wrrd 00; mem_addr 0; mem_wdata 0; all acks/rvalids 0; both rdata 0; busy 0; last_grant = BIP.
- FSM states:
  - IDLE: arbitrate; if any eligible request, go to ISSUE.
  - ISSUE: mem_wrrd, mem_addr, mem_wdata are driven from capture registers; the memory executes at this cycle's negedge; go to RESP.
  - RESP: mem_wrrd = 00; rvalid pulses if the op was a read; arbitrate exactly as in IDLE, going to ISSUE on a grant, else to IDLE.
- Arbitration edge:
  - Winner's op/addr/wdata are captured.
  - The winner's ack is high for the following cycle only (the ISSUE cycle).
  - The source id is stored for the response.
- Latency:
  - req sampled at edge k → ack and mem op in cycle k+1.
  - mem_rdata latched at edge k+2 → rvalid and rdata in cycle k+2.
  - Throughput: one access per 2 cycles.
- Handshake:
  - Requester holds req/op/addr/wdata stable until it sees ack.
  - req is not sampled in ISSUE; the requester has the ack cycle to drop req or present a new request.
  - rdata holds its value until the next read for that requester.
- Eligibility: BIP is eligible only when if_lock = 0.
- Simultaneous eligible requests: policy per the Optional Feature; last_grant updates on every grant.
- Illegal op (00 or 11):
  - Request is still acked.
  - mem_wrrd stays 00 in ISSUE.
  - No rvalid is issued.
- Write: no rvalid; rdata is unchanged.
- Reset mid-operation:
  - If rst_n is low at the edge ending ISSUE, the negedge access has already executed (a write lands), but rvalid is suppressed and the FSM returns to IDLE.
  - Pending reqs are not remembered.
- if_lock rising while a BIP access is in ISSUE/RESP: that access completes normally.
- Address range checking is not done here.

Optional Feature:
- DMEM_ARB_RR_EN defined: round-robin. On contention, the requester not in last_grant wins; the first contention after reset goes to the interface.
- Undefined: fixed priority, interface always beats BIP; last_grant is still tracked but unused.

Decomposition:
- Shared package/include dmem_pkg, holding:
  - OP_IDLE = 2'b00, OP_READ = 2'b01, OP_WRITE = 2'b10.
  - FSM state codes ST_IDLE, ST_ISSUE, ST_RESP.
  - Source ids SRC_BIP, SRC_IF.
- The data memory module imports the op codes from the same package.
- One sub-module, arb2_pick: combinational 2-way picker with inputs req[1:0] and last and a policy compiled by the macro; outputs a one-hot grant.

Test Plan:
- Memory preloaded [1,2,3,4,0,0]. BIP read addr 2 alone → bip_ack in cycle k+1; mem_wrrd = 01 and mem_addr = 2 in k+1; bip_rvalid in k+2 with bip_rdata = 3.
- Interface write addr 4, data 16'h00AA, then interface read addr 4 → write ack; no rvalid; read returns 16'h00AA; mem_wrrd never 11.
- Both requests held, reading addr 0 and addr 1:
  - With DMEM_ARB_RR_EN: grants alternate IF, BIP, IF, BIP; each rdata correct (1 for addr 0, 2 for addr 1).
  - Without it: IF is granted repeatedly and BIP starves while if_req stays high.
- if_lock = 1 with bip_req high for 10 cycles → no bip_ack. Drop lock → bip_ack within 2 cycles.
- BIP write addr 5, data 7; rst_n low at the edge ending ISSUE → memory[5] = 7; no ack or rvalid after reset; all outputs at reset values.
- BIP op = 11 → bip_ack pulses; mem_wrrd stays 00; no bip_rvalid; next request is served normally.
